// File: rtl/alu_srca_pipe.sv
// ---------------------------------------------------------------------------
// alu_srca_pipe
//   Registered operand-A selector sitting between ID and EX. One of NUM_SRC
//   sources is picked by sel (0=Register1, 1=PC, 2=EX/MEM fwd, 3=MEM/WB fwd,
//   higher=extra) and captured into a 2-entry skid buffer with valid/ready
//   handshakes on both sides. Strict FIFO order, no in->out combinational
//   path, no out_ready->in_ready combinational path.
//
//   Optional feature macro: ALU_SRCA_ZERO_EN
//     defined   : sel==NUM_SRC selects constant zero (LUI), no sel_err.
//     undefined : sel==NUM_SRC is out of range like any sel>NUM_SRC.
//
// Ports
//   clk        in   1             pipeline clock, rising edge
//   rst        in   1             asynchronous active-high reset
//   flush      in   1             synchronous flush, drops buffered operands
//   in_valid   in   1             decode offers an operand
//   in_ready   out  1             buffer can accept this cycle (registered)
//   sel        in   SEL_W         source select (unsigned)
//   src_data   in   NUM_SRC*XLEN  source k = src_data[k*XLEN +: XLEN]
//   out_valid  out  1             operand available to EX (registered)
//   out_ready  in   1             EX consumes operand this cycle
//   out_data   out  XLEN          head of buffer (registered)
//   sel_err    out  1             sticky: an out-of-range sel was accepted
// ---------------------------------------------------------------------------
module alu_srca_pipe #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_data,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // NUM_SRC always fits in SEL_W bits because SEL_W carries one spare bit.
    localparam logic [SEL_W-1:0] LP_NUM_SRC = SEL_W'(NUM_SRC);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_main;
    logic [XLEN-1:0]   r_skid;
    logic [XLEN-1:0]   w_main_nxt;
    logic [XLEN-1:0]   w_skid_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_sel_err;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_sel_bad;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign sel_err   = r_sel_err;

    // Select decode: in-range picks that source, out-of-range falls back to source 0.
    always_comb begin
        w_sel_data = src_data[XLEN-1:0];
        w_sel_bad  = 1'b0;
        if (sel < LP_NUM_SRC) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (sel == SEL_W'(k)) begin
                    w_sel_data = src_data[k*XLEN +: XLEN];
                end else begin
                    w_sel_data = w_sel_data;
                end
            end
        end
`ifdef ALU_SRCA_ZERO_EN
        else if (sel == LP_NUM_SRC) begin
            w_sel_data = {XLEN{1'b0}};
        end
`endif
        else begin
            w_sel_bad = 1'b1;
        end
    end

    // Buffer FSM next state and data steering; flush overrides the state only.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = w_sel_data;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && !w_out_xfer) begin
                    w_state_nxt = ST_FULL;
                    w_skid_nxt  = w_sel_data;
                end else if (w_out_xfer && !w_in_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_xfer && w_out_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = w_sel_data;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain can happen.
                if (w_out_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = r_skid;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State, data and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= {XLEN{1'b0}};
            r_skid      <= {XLEN{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Sticky select-error flag; only rst clears it, a flushed operand never sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_in_xfer && w_sel_bad && !flush) begin
            r_sel_err <= 1'b1;
        end else begin
            r_sel_err <= r_sel_err;
        end
    end

endmodule

// File: tb/tb_alu_srca_pipe.sv
module tb_alu_srca_pipe;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = $clog2(NUM_SRC) + 1;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_data;
    logic                    sel_err;

    int checks = 0;
    int errors = 0;

    alu_srca_pipe #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .src_data  (src_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] s3);
        src_data = {s3, s2, s1, s0};
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 3'd0;
        set_src(32'h11111111, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_sel_err",   {31'd0, sel_err}, 32'd0);
        rst = 1'b0;

        // T2: each select appears one cycle after its accept, in order.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel = 3'd0; step();
        chk("t2_valid0", {31'd0, out_valid}, 32'd1);
        chk("t2_sel0", out_data, 32'h11111111);
        sel = 3'd1; step();
        chk("t2_sel1", out_data, 32'h80000000);
        sel = 3'd2; step();
        chk("t2_sel2", out_data, 32'hDEADBEEF);
        sel = 3'd3; step();
        chk("t2_sel3", out_data, 32'h0000CAFE);
        chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0; step();
        chk("t2_drained", {31'd0, out_valid}, 32'd0);

        // T3: backpressure fills both entries, then drains in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 3'd0;
        set_src(32'h1, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE); step();
        chk("t3_a_data", out_data, 32'h1);
        chk("t3_a_ready", {31'd0, in_ready}, 32'd1);
        set_src(32'h2, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE); step();
        chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_full_head", out_data, 32'h1);
        in_valid = 1'b0;
        set_src(32'h9, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE); step();
        chk("t3_stall_head", out_data, 32'h1);
        chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1; step();
        chk("t3_b_data", out_data, 32'h2);
        chk("t3_b_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        chk("t3_empty", {31'd0, out_valid}, 32'd0);

        // T4: flush while FULL with a concurrent offer of 0x3.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_src(32'h4, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE); step();
        set_src(32'h5, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE); step();
        chk("t4_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        set_src(32'h3, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE); step();
        chk("t4_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_flush_ready", {31'd0, in_ready}, 32'd1);
        flush    = 1'b0;
        in_valid = 1'b0; step();
        chk("t4_no_ghost", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        set_src(32'h6, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE); step();
        chk("t4_after_data", out_data, 32'h6);
        in_valid  = 1'b0;
        out_ready = 1'b1; step();
        chk("t4_after_empty", {31'd0, out_valid}, 32'd0);

        // T5: sel=5 is out of range, falls back to source 0 and latches sel_err.
        in_valid = 1'b1;
        sel = 3'd5;
        set_src(32'hAAAA5555, 32'h80000000, 32'hDEADBEEF, 32'h0000CAFE); step();
        chk("t5_data", out_data, 32'hAAAA5555);
        chk("t5_err", {31'd0, sel_err}, 32'd1);
        in_valid = 1'b0; step();
        flush = 1'b1; step();
        flush = 1'b0;
        chk("t5_err_after_flush", {31'd0, sel_err}, 32'd1);

        // T1: async reset with two operands buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 3'd2; step();
        sel = 3'd3; step();
        chk("t1_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_out_data", out_data, 32'd0);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t1_sel_err", {31'd0, sel_err}, 32'd0);
        step();
        rst = 1'b0;

        // T6: sel==NUM_SRC, behaviour depends on the zero-operand option.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel = 3'd4; step();
        in_valid = 1'b0;
`ifdef ALU_SRCA_ZERO_EN
        chk("t6_data", out_data, 32'h0);
        chk("t6_err", {31'd0, sel_err}, 32'd0);
`else
        chk("t6_data", out_data, 32'hAAAA5555);
        chk("t6_err", {31'd0, sel_err}, 32'd1);
`endif
        step();
        chk("t6_empty", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
